// File: rtl/fft_input_buffer_if.sv
`timescale 1ns/1ps
// Sample/request bus of fft_input_buffer: capture stream in, one-word-per-request read path out.
// The master side drives samples and read requests. The slave side is the buffer.
interface fft_input_buffer_if #(
    parameter int Q_IN   = 15,
    parameter int Q_OUT  = 15,
    parameter int ADDR_W = 3
);
    // Handshake (no ready anywhere):
    // - sample_valid is a one-cycle write strobe. It is dropped, with overflow set, while both banks are full.
    // - valid_request is honoured only while valid_packet is high.
    // - Each honoured request is answered by a one-cycle valid_out on the following cycle.
    logic                  sample_valid;
    logic signed [Q_IN:0]  sample_in;
    logic                  valid_request;
    logic                  valid_packet;
    logic                  valid_out;
    logic signed [Q_OUT:0] data_out_real;
    logic [ADDR_W-1:0]     addr_out;
    logic                  overflow;

    modport master (
        output sample_valid, sample_in, valid_request,
        input  valid_packet, valid_out, data_out_real, addr_out, overflow
    );

    modport slave (
        input  sample_valid, sample_in, valid_request,
        output valid_packet, valid_out, data_out_real, addr_out, overflow
    );
endinterface

// File: rtl/fft_input_buffer.sv
`timescale 1ns/1ps
// Ping-pong input buffer for fft_stage_1: captures N-sample packets into two banks and returns them on request.
// Define FFT_INBUF_BITREV_EN to read in bit-reversed order; otherwise the read order is natural.
module fft_input_buffer #(
    parameter int Q_IN   = 15,
    parameter int Q_OUT  = 15,
    parameter int N      = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    fft_input_buffer_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    // Bank b occupies words [b*N, b*N+N-1].
    logic signed [Q_IN:0] mem [0:2*N-1];

    logic [1:0]            full_q, full_d;
    logic                  wbank_q, wbank_d;
    logic                  rbank_q, rbank_d;
    logic [ADDR_W-1:0]     widx_q, widx_d;
    logic [ADDR_W-1:0]     ridx_q, ridx_d;
    logic [ADDR_W-1:0]     raddr;

    logic                  wr_en, wr_last, drop;
    logic                  rd_en, rd_last;
    logic                  valid_packet_d;

    logic                  valid_packet_q;
    logic                  valid_out_q;
    logic signed [Q_OUT:0] data_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  overflow_q;

    logic signed [Q_IN:0]  rd_word;
    logic signed [Q_OUT:0] rd_conv;

`ifdef FFT_INBUF_BITREV_EN
    always_comb begin
        raddr = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            raddr[i] = ridx_q[ADDR_W-1-i];
        end
    end
`else
    assign raddr = ridx_q;
`endif

    assign rd_word = mem[{rbank_q, raddr}];

    // Narrowing keeps the MSBs: an arithmetic shift right without rounding.
    if (Q_OUT > Q_IN) begin : g_sign_extend
        assign rd_conv = {{(Q_OUT - Q_IN){rd_word[Q_IN]}}, rd_word};
    end else if (Q_OUT < Q_IN) begin : g_truncate
        assign rd_conv = rd_word[Q_IN -: Q_OUT + 1];
    end else begin : g_pass
        assign rd_conv = rd_word;
    end

    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        widx_d  = widx_q;
        rbank_d = rbank_q;
        ridx_d  = ridx_q;

        wr_en   = bus.sample_valid && !full_q[wbank_q];
        drop    = bus.sample_valid &&  full_q[wbank_q];
        wr_last = wr_en && (widx_q == LAST_IDX);
        rd_en   = bus.valid_request && valid_packet_q;
        rd_last = rd_en && (ridx_q == LAST_IDX);

        if (wr_en) begin
            widx_d = widx_q + ADDR_W'(1);
        end
        if (wr_last) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end
        if (rd_en) begin
            ridx_d = ridx_q + ADDR_W'(1);
        end
        // A read only happens from a full bank and a write only into an empty one.
        // Therefore set and clear never hit the same flag.
        if (rd_last) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end

        valid_packet_d = full_d[rbank_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q         <= '0;
            wbank_q        <= 1'b0;
            widx_q         <= '0;
            rbank_q        <= 1'b0;
            ridx_q         <= '0;
            valid_packet_q <= 1'b0;
            valid_out_q    <= 1'b0;
            data_q         <= '0;
            addr_q         <= '0;
            overflow_q     <= 1'b0;
        end else begin
            full_q         <= full_d;
            wbank_q        <= wbank_d;
            widx_q         <= widx_d;
            rbank_q        <= rbank_d;
            ridx_q         <= ridx_d;
            valid_packet_q <= valid_packet_d;
            valid_out_q    <= rd_en;
            if (rd_en) begin
                data_q <= rd_conv;
                addr_q <= raddr;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[{wbank_q, widx_q}] <= bus.sample_in;
        end
    end

    assign bus.valid_packet  = valid_packet_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.data_out_real = data_q;
    assign bus.addr_out      = addr_q;
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_fft_input_buffer.sv
`timescale 1ns/1ps
// Bench for fft_input_buffer: a 16-bit-out and an 8-bit-out instance share one input stream.
// Both are compared every cycle against a packet-queue model of the buffer.
module tb_fft_input_buffer;
    localparam int N      = 8;
    localparam int ADDR_W = 3;
    localparam int EW     = ADDR_W + 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_input_buffer_if #(.Q_IN(15), .Q_OUT(15), .ADDR_W(ADDR_W)) bus_w ();
    fft_input_buffer_if #(.Q_IN(15), .Q_OUT(7),  .ADDR_W(ADDR_W)) bus_n ();

    assign bus_n.sample_valid  = bus_w.sample_valid;
    assign bus_n.sample_in     = bus_w.sample_in;
    assign bus_n.valid_request = bus_w.valid_request;

    fft_input_buffer #(.Q_IN(15), .Q_OUT(15), .N(N), .ADDR_W(ADDR_W)) dut_w (
        .clk(clk), .reset(reset), .bus(bus_w));
    fft_input_buffer #(.Q_IN(15), .Q_OUT(7), .N(N), .ADDR_W(ADDR_W)) dut_n (
        .clk(clk), .reset(reset), .bus(bus_n));

    // Model: complete packets queued oldest-first, plus the packet being captured.
    logic [15:0]   store_q[$];
    logic [15:0]   cur_q[$];
    logic [EW-1:0] exp_q[$];
    int            rcnt;
    bit            ovf_m;
    logic [15:0]   hold_data;
    logic [ADDR_W-1:0] hold_addr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int order_addr(input int k);
        int r;
        r = k;
`ifdef FFT_INBUF_BITREV_EN
        r = 0;
        for (int b = 0; b < ADDR_W; b++) begin
            if ((k & (1 << b)) != 0) r = r | (1 << (ADDR_W - 1 - b));
        end
`endif
        return r;
    endfunction

    function automatic logic [7:0] narrow(input logic [15:0] v);
        logic signed [15:0] s;
        s = v;
        s = s >>> 8;
        return s[7:0];
    endfunction

    task automatic model_reset();
        store_q.delete();
        cur_q.delete();
        exp_q.delete();
        rcnt      = 0;
        ovf_m     = 1'b0;
        hold_data = '0;
        hold_addr = '0;
    endtask

    task automatic model_step(input bit sv, input logic [15:0] sin, input bit req);
        int  npk;
        int  a;
        bit  rd_last;
        npk     = store_q.size() / N;
        rd_last = 1'b0;
        if (req && npk > 0) begin
            a = order_addr(rcnt);
            exp_q.push_back({a[ADDR_W-1:0], store_q[a]});
            rcnt++;
            if (rcnt == N) rd_last = 1'b1;
        end
        if (sv) begin
            if (npk == 2) begin
                ovf_m = 1'b1;
            end else begin
                cur_q.push_back(sin);
                if (cur_q.size() == N) begin
                    foreach (cur_q[i]) store_q.push_back(cur_q[i]);
                    cur_q.delete();
                end
            end
        end
        if (rd_last) begin
            repeat (N) void'(store_q.pop_front());
            rcnt = 0;
        end
    endtask

    task automatic compare_outputs();
        logic [EW-1:0] e;
        bit exp_vo;
        exp_vo = (exp_q.size() > 0);
        check("valid_out", {31'h0, bus_w.valid_out}, {31'h0, exp_vo});
        check("valid_out_n", {31'h0, bus_n.valid_out}, {31'h0, exp_vo});
        if (exp_vo) begin
            e = exp_q.pop_front();
            hold_addr = e[EW-1:16];
            hold_data = e[15:0];
        end
        check("data", {16'h0, bus_w.data_out_real}, {16'h0, hold_data});
        check("addr", {29'h0, bus_w.addr_out}, {29'h0, hold_addr});
        check("data_n", {24'h0, bus_n.data_out_real}, {24'h0, narrow(hold_data)});
        check("valid_packet", {31'h0, bus_w.valid_packet}, {31'h0, store_q.size() >= N});
        check("valid_packet_n", {31'h0, bus_n.valid_packet}, {31'h0, store_q.size() >= N});
        check("overflow", {31'h0, bus_w.overflow}, {31'h0, ovf_m});
    endtask

    task automatic cycle(input bit sv, input logic [15:0] sin, input bit req);
        bus_w.sample_valid  = sv;
        bus_w.sample_in     = sin;
        bus_w.valid_request = req;
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(sv, sin, req);
        #1;
        compare_outputs();
    endtask

    int t1 [8];

    initial begin
`ifdef FFT_INBUF_BITREV_EN
        t1 = '{10, 14, 12, 16, 11, 15, 13, 17};
`else
        t1 = '{10, 11, 12, 13, 14, 15, 16, 17};
`endif
        reset = 1'b1;
        model_reset();
        cycle(0, 16'h0, 0);
        cycle(0, 16'h0, 0);
        reset = 1'b0;

        // Single packet, read back in order.
        for (int i = 0; i < N; i++) cycle(1, 16'(10 + i), 0);
        check("t1_vp", {31'h0, bus_w.valid_packet}, 32'h1);
        for (int i = 0; i < N; i++) begin
            cycle(0, 16'h0, 1);
            check("t1_order", {16'h0, bus_w.data_out_real}, t1[i]);
        end
        cycle(0, 16'h0, 0);

        // Requests with nothing buffered are ignored.
        repeat (3) cycle(0, 16'h0, 1);
        for (int i = 0; i < N; i++) cycle(1, 16'(100 + i), 0);
        cycle(0, 16'h0, 1);
        check("t2_first", {16'h0, bus_w.data_out_real}, 32'd100);
        repeat (N - 1) cycle(0, 16'h0, 1);

        // Fill both banks, overflow the third packet.
        for (int i = 0; i < 3 * N; i++) cycle(1, 16'(200 + i), 0);
        check("t3_ovf", {31'h0, bus_w.overflow}, 32'h1);
        repeat (2 * N) cycle(0, 16'h0, 1);
        cycle(0, 16'h0, 0);

        // Read one bank while capturing the other, last read and last write on one edge.
        for (int i = 0; i < N; i++) cycle(1, 16'(300 + i), 0);
        for (int i = 0; i < N; i++) cycle(1, 16'(400 + i), 1);
        check("t4_vp", {31'h0, bus_w.valid_packet}, 32'h1);
        repeat (N) cycle(0, 16'h0, 1);

        // Narrowing to 8 bits.
        for (int i = 0; i < N; i++) cycle(1, 16'h8000, 0);
        cycle(0, 16'h0, 1);
        check("t5_min", {24'h0, bus_n.data_out_real}, 32'h80);
        repeat (N - 1) cycle(0, 16'h0, 1);
        for (int i = 0; i < N; i++) cycle(1, 16'h7FFF, 0);
        cycle(0, 16'h0, 1);
        check("t5_max", {24'h0, bus_n.data_out_real}, 32'h7F);
        repeat (N - 1) cycle(0, 16'h0, 1);

        // Reset in the middle of a read.
        for (int i = 0; i < N; i++) cycle(1, 16'(500 + i), 0);
        repeat (3) cycle(0, 16'h0, 1);
        reset = 1'b1;
        cycle(0, 16'h0, 1);
        reset = 1'b0;
        check("t6_vp", {31'h0, bus_w.valid_packet}, 32'h0);
        check("t6_data", {16'h0, bus_w.data_out_real}, 32'h0);
        for (int i = 0; i < N; i++) cycle(1, 16'(600 + i), 0);
        cycle(0, 16'h0, 1);
        check("t6_addr", {29'h0, bus_w.addr_out}, 32'h0);
        check("t6_first", {16'h0, bus_w.data_out_real}, 32'd600);
        repeat (N - 1) cycle(0, 16'h0, 1);

        // Random traffic, then drain.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 99) < 55, 16'($urandom_range(0, 65535)),
                  $urandom_range(0, 99) < 45);
        end
        repeat (2 * N + 2) cycle(0, 16'h0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
